// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with architectural NZCV flags, stall/flush and saturating perf counters
module ex_mem_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_n,
    input  logic              ex_z,
    input  logic              ex_c,
    input  logic              ex_v,
    input  logic              ex_set_flags,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_wr,
    output logic              mem_mem_rd,
    output logic              mem_mem_wr,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic load;
    logic stall_inc;
    logic bubble_inc;

    assign load       = !flush && !stall;
    assign stall_inc  = stall && !flush;
    assign bubble_inc = flush || (load && !ex_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_rd         <= '0;
            mem_reg_wr     <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
            {flag_n, flag_z, flag_c, flag_v} <= 4'b0000;
            stall_cnt      <= '0;
            bubble_cnt     <= '0;
        end else begin
            if (flush) begin
                mem_valid  <= 1'b0;
                mem_reg_wr <= 1'b0;
                mem_mem_rd <= 1'b0;
                mem_mem_wr <= 1'b0;
            end else if (!stall) begin
                mem_valid      <= ex_valid;
                mem_result     <= ex_result;
                mem_rd         <= ex_rd;
                mem_store_data <= ex_store_data;
                mem_reg_wr     <= ex_reg_wr & ex_valid;
                mem_mem_rd     <= ex_mem_rd & ex_valid;
                mem_mem_wr     <= ex_mem_wr & ex_valid;
                if (ex_valid && ex_set_flags)
                    {flag_n, flag_z, flag_c, flag_v} <= {ex_n, ex_z, ex_c, ex_v};
            end
            // clear wins over increment; counters stick at all-ones
            if (cnt_clr) begin
                stall_cnt  <= '0;
                bubble_cnt <= '0;
            end else begin
                if (stall_inc && stall_cnt != '1)
                    stall_cnt <= stall_cnt + 1'b1;
                if (bubble_inc && bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
endmodule
